// File: rtl/io_out_bank.sv
// Registered, double-buffered output bank with a delayed output-enable sequencer
// and a commit watchdog that parks the pads on a safe pattern when commits stall.
module io_out_bank #(
  parameter int unsigned       WIDTH      = 4,
  parameter logic [WIDTH-1:0]  SAFE_VALUE = '0,
  parameter int unsigned       OE_DELAY   = 4,
  parameter int unsigned       TIMEOUT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wr,
  input  logic             commit,
  input  logic             oe_req,
  input  logic             fault_clr,
  output logic [WIDTH-1:0] pad_out,
  output logic             pad_oe,
  output logic [1:0]       state,
  output logic             fault
);

  localparam int unsigned CMAX_A = (OE_DELAY > 2) ? OE_DELAY : 2;
  localparam int unsigned CMAX   = (TIMEOUT > CMAX_A) ? TIMEOUT : CMAX_A;
  localparam int unsigned CW     = $clog2(CMAX);

  localparam logic [CW-1:0] ARM_LAST = CW'(OE_DELAY - 1);
  localparam logic [CW-1:0] WD_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_ARM   = 2'b01,
    S_RUN   = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_pad_out;
  logic             r_pad_oe;
  logic             r_fault;
  logic [CW-1:0]    r_arm_cnt;
  logic [CW-1:0]    r_wd_cnt;

  logic [WIDTH-1:0] w_out_next;
  logic [CW-1:0]    w_arm_inc;
  logic [CW-1:0]    w_wd_inc;
  logic             w_timeout;

  // A same-cycle write bypasses the shadow so wr+commit lands the new word at once.
  assign w_out_next = commit ? (wr ? wdata : r_shadow) : r_out;
  assign w_arm_inc  = (r_arm_cnt == '1) ? r_arm_cnt : r_arm_cnt + CW'(1);
  assign w_wd_inc   = (TIMEOUT == 0) ? '0
                    : ((r_wd_cnt == '1) ? r_wd_cnt : r_wd_cnt + CW'(1));
  assign w_timeout  = (TIMEOUT != 0) && (r_wd_cnt == WD_LAST) && !commit;

  // Pad outputs are registered from next-state values so they change with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_OFF;
      r_shadow  <= SAFE_VALUE;
      r_out     <= SAFE_VALUE;
      r_pad_out <= SAFE_VALUE;
      r_pad_oe  <= 1'b0;
      r_fault   <= 1'b0;
      r_arm_cnt <= '0;
      r_wd_cnt  <= '0;
    end else begin
      if (wr) r_shadow <= wdata;
      r_out     <= w_out_next;
      r_pad_out <= SAFE_VALUE;
      r_pad_oe  <= 1'b0;
      case (r_state)
        S_OFF: begin
          if (oe_req) begin
            r_state   <= S_ARM;
            r_arm_cnt <= '0;
          end
        end
        S_ARM: begin
          if (!oe_req) begin
            r_state <= S_OFF;
          end else if (r_arm_cnt == ARM_LAST) begin
            r_state   <= S_RUN;
            r_wd_cnt  <= '0;
            r_pad_oe  <= 1'b1;
            r_pad_out <= w_out_next;
          end else begin
            r_arm_cnt <= w_arm_inc;
          end
        end
        S_RUN: begin
          if (w_timeout) begin
            r_state  <= S_FAULT;
            r_fault  <= 1'b1;
            r_pad_oe <= 1'b1;
          end else if (!oe_req) begin
            r_state <= S_OFF;
          end else begin
            r_pad_oe  <= 1'b1;
            r_pad_out <= w_out_next;
            r_wd_cnt  <= commit ? '0 : w_wd_inc;
          end
        end
        S_FAULT: begin
          if (fault_clr && !oe_req) begin
            r_state <= S_OFF;
            r_fault <= 1'b0;
          end else begin
            r_pad_oe <= 1'b1;
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  assign pad_out = r_pad_out;
  assign pad_oe  = r_pad_oe;
  assign state   = r_state;
  assign fault   = r_fault;

endmodule

// File: tb/tb_io_out_bank.sv
// Bench for io_out_bank: per-cycle scoreboard fed by a behavioural model, plus
// directed latency checks for enable, abort, watchdog and fault clear.
module tb_io_out_bank;

  localparam int unsigned W        = 4;
  localparam logic [3:0]  SAFE     = 4'h6;
  localparam int unsigned OE_DELAY = 4;
  localparam int unsigned TIMEOUT  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       commit = 1'b0;
  logic       oe_req = 1'b0;
  logic       fault_clr = 1'b0;
  logic [3:0] wdata = '0;
  logic [3:0] pad_out;
  logic       pad_oe;
  logic [1:0] state;
  logic       fault;

  io_out_bank #(
    .WIDTH(W),
    .SAFE_VALUE(SAFE),
    .OE_DELAY(OE_DELAY),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wdata(wdata),
    .wr(wr),
    .commit(commit),
    .oe_req(oe_req),
    .fault_clr(fault_clr),
    .pad_out(pad_out),
    .pad_oe(pad_oe),
    .state(state),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] po;
    logic       oe;
    logic [1:0] st;
    logic       f;
    string      tag;
  } exp_t;

  exp_t  q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_tag = "init";

  // Reference model: mode 0 OFF, 1 ARM, 2 RUN, 3 FAULT.
  logic [3:0] m_shadow = SAFE;
  logic [3:0] m_out    = SAFE;
  int         m_mode   = 0;
  int         m_age    = 0;
  int         m_idle   = 0;

  task automatic model_step(input logic r, input logic w, input logic [3:0] d,
                            input logic c, input logic o, input logic fc);
    logic [3:0] nout;
    exp_t e;
    if (!r) begin
      m_shadow = SAFE; m_out = SAFE; m_mode = 0; m_age = 0; m_idle = 0;
    end else begin
      nout = c ? (w ? d : m_shadow) : m_out;
      if (w) m_shadow = d;
      m_out = nout;
      case (m_mode)
        0: if (o) begin m_mode = 1; m_age = 0; end
        1: begin
          if (!o) m_mode = 0;
          else begin
            m_age = m_age + 1;
            if (m_age == int'(OE_DELAY)) begin m_mode = 2; m_idle = 0; end
          end
        end
        2: begin
          m_idle = c ? 0 : m_idle + 1;
          if (TIMEOUT > 0 && m_idle >= int'(TIMEOUT)) m_mode = 3;
          else if (!o) m_mode = 0;
        end
        default: if (fc && !o) m_mode = 0;
      endcase
    end
    e.po  = (m_mode == 2) ? m_out : SAFE;
    e.oe  = (m_mode >= 2);
    e.st  = 2'(m_mode);
    e.f   = (m_mode == 3);
    e.tag = cur_tag;
    q.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic w, input logic [3:0] d,
                       input logic c, input logic o, input logic fc);
    @(posedge clk);
    #2;
    rst_n = r; wr = w; wdata = d; commit = c; oe_req = o; fault_clr = fc;
    model_step(r, w, d, c, o, fc);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: compares every registered output sample against the queued expectation.
  exp_t me;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        me = q.pop_front();
        n_tests++;
        if ({pad_out, pad_oe, state, fault} !== {me.po, me.oe, me.st, me.f}) begin
          n_fail++;
          $display("FAIL sb_%s: pad_out=%h pad_oe=%b state=%b fault=%b expected %h %b %b %b",
                   me.tag, pad_out, pad_oe, state, fault, me.po, me.oe, me.st, me.f);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  int   lat;
  int   kf;
  int   st8;
  logic oe_seen;
  logic oe_r;

  initial begin
    cur_tag = "reset";
    repeat (4) cycle(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
    chk("reset_pad_out", int'(pad_out), int'(SAFE));
    chk("reset_pad_oe", int'(pad_oe), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_fault", int'(fault), 0);

    cur_tag = "off";
    repeat (3) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    cur_tag = "enable";
    cycle(1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    lat = 0;
    for (int j = 1; j <= 12 && lat == 0; j++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      if (pad_oe) lat = j;
    end
    chk("enable_latency", lat, int'(OE_DELAY) + 1);
    chk("enable_pad_out", int'(pad_out), 'hA);
    chk("enable_state", int'(state), 2);

    cur_tag = "atomic";
    cycle(1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    chk("atomic_hold0", int'(pad_out), 'hA);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("atomic_hold1", int'(pad_out), 'hA);
    cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("atomic_hold2", int'(pad_out), 'hA);
    cycle(1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
    chk("atomic_commit", int'(pad_out), 'h5);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("atomic_bypass", int'(pad_out), 'h3);

    cur_tag = "abort";
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("run_drop_state", int'(state), 0);
    oe_seen = 1'b0;
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    oe_seen |= pad_oe;
    for (int j = 0; j < 8; j++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      oe_seen |= pad_oe;
    end
    chk("abort_state", int'(state), 0);
    chk("abort_oe_never", int'(oe_seen), 0);

    cur_tag = "watchdog";
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    lat = 0;
    for (int j = 1; j <= 12 && lat == 0; j++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      if (pad_oe) lat = j;
    end
    kf = 0;
    for (int k = 1; k <= 24 && kf == 0; k++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      if (fault) kf = k;
    end
    chk("wd_latency", kf, int'(TIMEOUT));
    chk("wd_state", int'(state), 3);
    chk("wd_pad_out", int'(pad_out), int'(SAFE));
    chk("wd_pad_oe", int'(pad_oe), 1);

    cur_tag = "fault_clr";
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("clr_ignored_fault", int'(fault), 1);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("clr_state", int'(state), 0);
    chk("clr_fault", int'(fault), 0);
    chk("clr_pad_oe", int'(pad_oe), 0);

    cur_tag = "wd_commit";
    cycle(1'b1, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
    lat = 0;
    for (int j = 1; j <= 12 && lat == 0; j++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      if (pad_oe) lat = j;
    end
    kf = 0;
    st8 = -1;
    for (int k = 1; k <= 30 && kf == 0; k++) begin
      cycle(1'b1, 1'b0, 4'h0, (k == 7), 1'b1, 1'b0);
      if (k == 8) st8 = int'(state);
      if (fault) kf = k;
    end
    chk("wd_commit_saved", st8, 2);
    chk("wd_commit_latency", kf, 2 * int'(TIMEOUT));
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    cur_tag = "random";
    oe_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) oe_r = ~oe_r;
      cycle(($urandom_range(0, 99) != 0), 1'($urandom), 4'($urandom),
            ($urandom_range(0, 9) == 0), oe_r, ($urandom_range(0, 5) == 0));
    end

    cur_tag = "drain";
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
